// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the core's execute stage to a handshaked word-wide data bus.
// Handles lane steering, byte enables, load extension, alignment checks and access timeout.
module lsu_bus_if #(
  parameter int XLEN      = 32,
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            done,
  output logic            fault,
  output logic [XLEN-1:0] rdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                state_reg, state_next;
  logic [TIMEOUT_W-1:0]  cnt_reg, cnt_next;
  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            lane_reg;
  logic [XLEN-1:0]       addr_reg;
  logic [XLEN-1:0]       wdata_reg;
  logic [3:0]            be_reg;
  logic [XLEN-1:0]       rdata_reg, rdata_next;
  logic                  fault_reg, fault_next;

  logic                  req_legal;
  logic                  req_aligned;
  logic                  req_ok;
  logic                  accept;
  logic [3:0]            be_steer;
  logic [XLEN-1:0]       wdata_steer;
  logic [7:0]            rd_byte [4];
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [XLEN-1:0]       load_ext;

  // Request decode: funct3 legality depends on direction, alignment on access width.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = ~req_we;
      default:                req_legal = 1'b0;
    endcase
    req_aligned = 1'b1;
    case (req_funct3[1:0])
      2'b01:   req_aligned = (req_addr[0] == 1'b0);
      2'b10:   req_aligned = (req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
  end

  assign req_ok = req_legal & req_aligned;
  assign accept = (state_reg == IDLE) & req_valid & req_ok;

  // Store lanes replicate the datum across the word; loads fetch the full word.
  always_comb begin
    be_steer    = 4'b1111;
    wdata_steer = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_steer    = 4'b0001 << req_addr[1:0];
          wdata_steer = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_steer    = 4'b0011 << req_addr[1:0];
          wdata_steer = {2{req_wdata[15:0]}};
        end
        default: begin
          be_steer    = 4'b1111;
          wdata_steer = req_wdata;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_byte[gi] = bus_rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rd_byte[lane_reg];
  assign half_sel = lane_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    load_ext = bus_rdata;
    case (funct3_reg)
      3'b000:  load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    fault_next = fault_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_ok) begin
            state_next = REQ;
            cnt_next   = '0;
          end else begin
            state_next = DONE;
            fault_next = 1'b1;
            rdata_next = '0;
          end
        end
      end
      REQ: begin
        // An ack arriving on the final allowed cycle still completes cleanly.
        if (bus_ack) begin
          state_next = DONE;
          fault_next = 1'b0;
          rdata_next = we_reg ? '0 : load_ext;
        end else if (cnt_reg == TIMEOUT_W'(TIMEOUT - 1)) begin
          state_next = DONE;
          fault_next = 1'b1;
          rdata_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      fault_reg <= fault_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      lane_reg   <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      be_reg     <= 4'b0000;
    end else if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      lane_reg   <= req_addr[1:0];
      addr_reg   <= {req_addr[XLEN-1:2], 2'b00};
      wdata_reg  <= wdata_steer;
      be_reg     <= be_steer;
    end
  end

  // Gating with rst lets an aborted access release the core in the same cycle.
  assign stall     = ~rst & (((state_reg == IDLE) & req_valid) | (state_reg == REQ));
  assign bus_req   = ~rst & (state_reg == REQ);
  assign done      = (state_reg == DONE);
  assign fault     = fault_reg & done;
  assign rdata     = rdata_reg;
  assign bus_we    = we_reg;
  assign bus_addr  = addr_reg;
  assign bus_wdata = wdata_reg;
  assign bus_be    = be_reg;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: loads, stores, faults, timeout and mid-access reset.
module tb_lsu_bus_if;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall, done, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  lsu_bus_if #(.XLEN(32), .TIMEOUT(16), .TIMEOUT_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .fault(fault), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next falling edge; outputs are stable there.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    #1;
  endtask

  task automatic release_req();
    req_valid = 1'b0;
    bus_ack   = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    total_cnt++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req got %0b want 0", bus_req); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata); else pass_cnt++;
    total_cnt++; if (bus_be !== 4'b0000 || bus_addr !== 32'h0) $display("FAIL rst_bus got be=%b addr=%h want 0000/0", bus_be, bus_addr); else pass_cnt++;
    rst = 1'b0;
    cyc();
    total_cnt++; if (stall !== 1'b0) $display("FAIL idle_stall got %0b want 0", stall); else pass_cnt++;
  endtask

  task automatic test_lb();
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    total_cnt++; if (stall !== 1'b1) $display("FAIL lb_c1_stall got %0b want 1", stall); else pass_cnt++;
    cyc();
    total_cnt++; if (bus_req !== 1'b1 || bus_we !== 1'b0) $display("FAIL lb_c2_req got req=%0b we=%0b want 1/0", bus_req, bus_we); else pass_cnt++;
    total_cnt++; if (bus_addr !== 32'h100) $display("FAIL lb_addr got %h want 00000100", bus_addr); else pass_cnt++;
    total_cnt++; if (bus_be !== 4'b1111) $display("FAIL lb_be got %b want 1111", bus_be); else pass_cnt++;
    bus_ack = 1'b1; bus_rdata = 32'h80FF1234;
    cyc();
    total_cnt++; if (done !== 1'b1 || fault !== 1'b0) $display("FAIL lb_c3_done got done=%0b fault=%0b want 1/0", done, fault); else pass_cnt++;
    total_cnt++; if (rdata !== 32'hFFFFFF80) $display("FAIL lb_rdata got %h want ffffff80", rdata); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0 || bus_req !== 1'b0) $display("FAIL lb_c3_stall got stall=%0b req=%0b want 0/0", stall, bus_req); else pass_cnt++;
    $display("LB   addr=00000103 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
    total_cnt++; if (done !== 1'b0) $display("FAIL lb_done_pulse got %0b want 0", done); else pass_cnt++;
  endtask

  task automatic test_half_loads();
    issue(1'b0, 3'b101, 32'h102, 32'h0);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'h80FF1234;
    cyc();
    total_cnt++; if (done !== 1'b1 || rdata !== 32'h000080FF) $display("FAIL lhu_rdata got done=%0b rdata=%h want 1/000080ff", done, rdata); else pass_cnt++;
    $display("LHU  addr=00000102 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
    issue(1'b0, 3'b001, 32'h100, 32'h0);
    cyc();
    bus_ack = 1'b1;
    cyc();
    total_cnt++; if (done !== 1'b1 || rdata !== 32'h00001234) $display("FAIL lh_rdata got done=%0b rdata=%h want 1/00001234", done, rdata); else pass_cnt++;
    $display("LH   addr=00000100 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    cyc();
    bus_ack = 1'b1;
    cyc();
    total_cnt++; if (rdata !== 32'hFFFF80FF) $display("FAIL lh_hi_rdata got %h want ffff80ff", rdata); else pass_cnt++;
    $display("LH   addr=00000102 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
  endtask

  task automatic test_fault();
    issue(1'b0, 3'b010, 32'h101, 32'h0);
    total_cnt++; if (stall !== 1'b1 || bus_req !== 1'b0) $display("FAIL lwmis_c1 got stall=%0b req=%0b want 1/0", stall, bus_req); else pass_cnt++;
    cyc();
    total_cnt++; if (done !== 1'b1 || fault !== 1'b1 || bus_req !== 1'b0) $display("FAIL lwmis_c2 got done=%0b fault=%0b req=%0b want 1/1/0", done, fault, bus_req); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL lwmis_rdata got %h want 0", rdata); else pass_cnt++;
    $display("LW   addr=00000101 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    cyc();
    total_cnt++; if (done !== 1'b1 || fault !== 1'b1 || bus_req !== 1'b0) $display("FAIL f3_011 got done=%0b fault=%0b req=%0b want 1/1/0", done, fault, bus_req); else pass_cnt++;
    $display("F011 addr=00000100 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
    issue(1'b1, 3'b100, 32'h100, 32'h0);
    cyc();
    total_cnt++; if (done !== 1'b1 || fault !== 1'b1) $display("FAIL sbu_illegal got done=%0b fault=%0b want 1/1", done, fault); else pass_cnt++;
    $display("S100 addr=00000100 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
  endtask

  task automatic test_store();
    int stall_cycles;
    // Leave a nonzero rdata behind so the store's zeroing is observable.
    issue(1'b0, 3'b010, 32'h104, 32'h0);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    cyc();
    total_cnt++; if (rdata !== 32'h12345678) $display("FAIL lw_rdata got %h want 12345678", rdata); else pass_cnt++;
    $display("LW   addr=00000104 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
    issue(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
    stall_cycles = 0;
    if (stall === 1'b1) stall_cycles++;
    cyc();
    total_cnt++; if (bus_we !== 1'b1 || bus_be !== 4'b1100) $display("FAIL sh_lanes got we=%0b be=%b want 1/1100", bus_we, bus_be); else pass_cnt++;
    total_cnt++; if (bus_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata got %h want abcdabcd", bus_wdata); else pass_cnt++;
    if (stall === 1'b1) stall_cycles++;
    cyc();
    if (stall === 1'b1) stall_cycles++;
    cyc();
    if (stall === 1'b1) stall_cycles++;
    total_cnt++; if (bus_req !== 1'b1 || done !== 1'b0) $display("FAIL sh_c4 got req=%0b done=%0b want 1/0", bus_req, done); else pass_cnt++;
    bus_ack = 1'b1;
    cyc();
    if (stall === 1'b1) stall_cycles++;
    total_cnt++; if (stall_cycles != 4) $display("FAIL sh_stall_cycles got %0d want 4", stall_cycles); else pass_cnt++;
    total_cnt++; if (done !== 1'b1 || fault !== 1'b0 || rdata !== 32'h0) $display("FAIL sh_c5 got done=%0b fault=%0b rdata=%h want 1/0/0", done, fault, rdata); else pass_cnt++;
    $display("SH   addr=00000102 wdata=%h be=%b fault=%0b", bus_wdata, bus_be, fault);
    release_req();
    cyc();
    issue(1'b1, 3'b000, 32'h101, 32'h000000A5);
    cyc();
    total_cnt++; if (bus_be !== 4'b0010 || bus_wdata !== 32'hA5A5A5A5) $display("FAIL sb_lanes got be=%b wdata=%h want 0010/a5a5a5a5", bus_be, bus_wdata); else pass_cnt++;
    bus_ack = 1'b1;
    cyc();
    $display("SB   addr=00000101 wdata=%h be=%b fault=%0b", bus_wdata, bus_be, fault);
    release_req();
    cyc();
  endtask

  task automatic test_timeout();
    int req_cycles;
    issue(1'b1, 3'b010, 32'h200, 32'hCAFEF00D);
    cyc();
    req_cycles = 0;
    while (bus_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      cyc();
    end
    total_cnt++; if (req_cycles != 16) $display("FAIL to_req_cycles got %0d want 16", req_cycles); else pass_cnt++;
    total_cnt++; if (done !== 1'b1 || fault !== 1'b1) $display("FAIL to_fault got done=%0b fault=%0b want 1/1", done, fault); else pass_cnt++;
    $display("SW   addr=00000200 timeout fault=%0b", fault);
    release_req();
    cyc();
    issue(1'b1, 3'b010, 32'h200, 32'hCAFEF00D);
    cyc();
    for (int i = 0; i < 15; i++) cyc();
    total_cnt++; if (bus_req !== 1'b1) $display("FAIL to16_req got %0b want 1", bus_req); else pass_cnt++;
    bus_ack = 1'b1;
    cyc();
    total_cnt++; if (done !== 1'b1 || fault !== 1'b0) $display("FAIL to16_ack got done=%0b fault=%0b want 1/0", done, fault); else pass_cnt++;
    $display("SW   addr=00000200 ack@16 fault=%0b", fault);
    release_req();
    cyc();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    cyc();
    cyc();
    cyc();
    total_cnt++; if (bus_req !== 1'b1) $display("FAIL rmid_pre_req got %0b want 1", bus_req); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus_req !== 1'b0 || stall !== 1'b0) $display("FAIL rmid_drop got req=%0b stall=%0b want 0/0", bus_req, stall); else pass_cnt++;
    cyc();
    rst = 1'b0;
    req_valid = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done === 1'b1) done_seen++;
    end
    total_cnt++; if (done_seen != 0) $display("FAIL rmid_no_done got %0d pulses want 0", done_seen); else pass_cnt++;
    $display("LW   addr=00000300 aborted by reset");
    issue(1'b0, 3'b010, 32'h304, 32'h0);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    cyc();
    total_cnt++; if (done !== 1'b1 || fault !== 1'b0 || rdata !== 32'hDEADBEEF) $display("FAIL rmid_next got done=%0b fault=%0b rdata=%h want 1/0/deadbeef", done, fault, rdata); else pass_cnt++;
    $display("LW   addr=00000304 rdata=%h fault=%0b", rdata, fault);
    release_req();
    cyc();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_half_loads();
    test_fault();
    test_store();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
